if_prefetch_buffer: RTL and testbench
=====================================

Name: if_prefetch_buffer

Overview:
Instruction prefetch queue sitting directly upstream of the IF stage of the 5-stage RISC-V pipeline. It issues sequential fetches to instruction memory over a req/gnt/rvalid bus and buffers the returned {pc, instr} pairs in an in-order FIFO. IF pops entries with a valid/ready handshake; ready is driven from the hazard unit's PCWrite/Write_IFID. A taken branch (PCSrc with the MEM-stage target) redirects fetch, flushes the queue and discards in-flight responses.

Parameters:
DEPTH, 4, FIFO entries and max in-flight credits; power of 2, minimum 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
redirect  in  1  taken branch (PCSrc), single-cycle pulse
redirect_pc  in  32  branch target (PC_EXMEM)
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid; responses in order, at least 1 cycle after gnt
imem_rdata  in  32  instruction word
out_valid  out  1  FIFO head valid
out_pc  out  32  PC of head entry
out_instr  out  32  instruction of head entry
out_ready  in  1  IF accepts head (PCWrite & Write_IFID)

Behaviour:
- Reset: state=FETCH, fetch_pc=RESET_PC, FIFO empty, inflight=0, discard=0; imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0.
- Counters inflight and discard are clog2(DEPTH)+1 bits wide. FIFO count is kept separately from the pointers so full is unambiguous.
- Credit rule: in FETCH, imem_req=1 iff fifo_count + inflight < DEPTH. imem_addr=fetch_pc.
- While req=1 without gnt, addr holds stable. The only exception is redirect, which may withdraw or retarget the request.
- On gnt: inflight++, fetch_pc += 4, wrapping modulo 2^32.
- On rvalid with discard=0: push {pc_of_oldest_inflight, imem_rdata} and decrement inflight. Issued PCs are tracked in a DEPTH-entry PC queue, or derived as head-PC arithmetic.
- Accepted response plus pop in the same cycle is allowed. Overflow is impossible by the credit rule; an rvalid with inflight=0 is ignored and fires an assertion.
- out_valid = FIFO non-empty, taken combinationally from registered state. out_pc/out_instr show the head entry. Pop occurs when out_valid & out_ready.
- Redirect, with priority over pop, push and gnt in the same cycle:
  - FIFO cleared and any pop in that cycle discarded.
  - fetch_pc = redirect_pc.
  - discard = inflight + (imem_gnt & imem_req) - imem_rvalid, clamped at 0. inflight is cleared to 0.
  - Next state is DRAIN if discard > 0, else FETCH.
- FSM:
  - FETCH: normal operation.
  - DRAIN: imem_req=0. Each rvalid decrements discard and its data is dropped. Go to FETCH when discard reaches 0 via its last rvalid.
  - A redirect in DRAIN reloads fetch_pc, keeps discard (no new grants), and stays in DRAIN.
- redirect_pc[1:0] is ignored; it is forced to 2'b00.
- Reset asserted mid-transaction returns immediately to reset values. Memory responses pending at reset are the memory's responsibility, since imem shares the reset.
- Latency: first out_valid at 2 cycles after the grant for a 1-cycle-latency memory (rvalid at T+1, registered push, valid at T+2).

Optional Feature:
- Macro: IFPB_PERF_CNT_EN.
- When defined, three extra 32-bit output ports are added:
  - perf_fetch_cnt: increments on every gnt.
  - perf_flush_cnt: increments on every redirect.
  - perf_discard_cnt: increments on every dropped rvalid.
  - All are reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package rv_pipe_pkg holds: localparam INSTR_NOP=32'h0000_0013, XLEN=32, PC_STEP=4, typedef fetch_entry_t {pc[31:0], instr[31:0]}, and enum ifpb_state_t {FETCH, DRAIN}.
- One sub-module, ifpb_fifo: a synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count, empty and full. It is instantiated for the data queue, and optionally also for the PC tracking queue.

Test Plan:
- Streaming: 1-cycle memory, gnt always 1, out_ready=1. Expect out_pc 0,4,8,12,... on consecutive cycles from cycle 3 after reset release, with instr matching mem[pc>>2].
- Backpressure: out_ready=0 for 10 cycles. Expect imem_req to fall after exactly 4 grants. FIFO holds pc 0..12. On releasing ready, the entries drain in order with no loss or duplicate.
- Redirect with 2 in flight: 3-cycle memory latency, redirect to 32'h100 while inflight=2. Expect FSM in DRAIN, two responses dropped, and the next out_pc=32'h100 with no stale entry visible.
- Redirect coinciding with gnt and rvalid in the same cycle. Expect discard computed as inflight+1-1, the popped head discarded, and a fetch address sequence of 0x100, 0x104.
- Wrap and stall: redirect_pc=32'hFFFF_FFFC with gnt held low for 5 cycles. Expect imem_addr stable at FFFF_FFFC, then 0x0000_0000 after the grant.
- Reset mid-DRAIN: assert rst asynchronously. Expect all outputs at reset values within the same cycle and fetch resuming at RESET_PC.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RISC-V fetch front end.
package rv_pipe_pkg;

  localparam int          XLEN      = 32;
  localparam int          PC_STEP   = 4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // One buffered fetch result: the PC it was fetched from and the word returned.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // FETCH issues requests; DRAIN swallows responses that a redirect made stale.
  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } ifpb_state_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

  // Saturating event counter step.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/ifpb_fifo.sv
// Synchronous in-order FIFO of fetch entries with a synchronous flush.
// Occupancy is held in its own counter so full and empty never alias.
module ifpb_fifo
  import rv_pipe_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t dout,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy; flush empties the queue without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage write port.
  // NOTE: storage has no reset; entries are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch queue in front of the IF stage. Issues sequential
// word fetches under a credit limit, buffers {pc, instr} in order, and on a
// taken branch flushes the queue and drains responses already in flight.
// Optional build macro IFPB_PERF_CNT_EN adds saturating fetch/flush/discard
// event counters as extra output ports.
module if_prefetch_buffer
  import rv_pipe_pkg::*;
#(
  parameter int          DEPTH    = 4,             // power of 2, at least 2
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
`ifdef IFPB_PERF_CNT_EN
  input  logic        out_ready,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_discard_cnt
`else
  input  logic        out_ready
`endif
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  ifpb_state_t     state,    state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [CW-1:0]   inflight, inflight_n;
  logic [CW-1:0]   discard,  discard_n;
  logic            req_q,    req_n;

  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   fifo_count_n;
  logic            fifo_empty;
  logic            fifo_full;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  logic            gnt_acc;
  logic            rsp_ok;
  logic            push;
  logic            pop;
  logic [CW:0]     owed;

  // Handshake qualification; a redirect cancels any push or pop in its cycle.
  always_comb begin
    gnt_acc = imem_req & imem_gnt;
    rsp_ok  = imem_rvalid & (state == FETCH) & (inflight != '0);
    push    = rsp_ok & ~redirect;
    pop     = out_valid & out_ready & ~redirect;
    // Fetches since the last redirect are sequential, so the oldest
    // outstanding PC sits inflight words behind the next fetch address.
    push_entry.pc    = fetch_pc - XLEN'({inflight, 2'b00});
    push_entry.instr = imem_rdata;
  end

  ifpb_fifo #(
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .flush (redirect),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Next-state logic for the fetch FSM, credits and discard counter.
  always_comb begin
    // NOTE: every value assigned here gets a default first, so no branch infers a latch.
    state_n      = state;
    fetch_pc_n   = fetch_pc;
    inflight_n   = inflight;
    discard_n    = discard;
    fifo_count_n = fifo_count + CW'(push) - CW'(pop);
    owed         = {1'b0, inflight} + (CW + 1)'(gnt_acc);

    if (redirect) begin
      fetch_pc_n   = align_pc(redirect_pc);
      inflight_n   = '0;
      fifo_count_n = '0;
      if (state == FETCH) begin
        // Everything granted but not yet returned becomes stale.
        discard_n = (owed > (CW + 1)'(imem_rvalid)) ? CW'(owed - (CW + 1)'(imem_rvalid)) : '0;
      end else if (imem_rvalid && (discard != '0)) begin
        discard_n = discard - CW'(1);
      end
      state_n = (discard_n != '0) ? DRAIN : FETCH;
    end else if (state == FETCH) begin
      if (gnt_acc) fetch_pc_n = fetch_pc + XLEN'(PC_STEP);
      inflight_n = inflight + CW'(gnt_acc) - CW'(rsp_ok);
    end else begin
      if (imem_rvalid && (discard != '0)) discard_n = discard - CW'(1);
      if (discard_n == '0) state_n = FETCH;
    end

    // Request only while every outstanding fetch is guaranteed a FIFO slot.
    req_n = (state_n == FETCH) && (({1'b0, fifo_count_n} + {1'b0, inflight_n}) < DEPTH_W);
  end

  // FSM and fetch-side state registers; the request is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      req_q    <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      inflight <= inflight_n;
      discard  <= discard_n;
      req_q    <= req_n;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = fetch_pc;
  assign out_valid = ~fifo_empty;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;

`ifdef IFPB_PERF_CNT_EN
  logic drop;
  assign drop = (imem_rvalid & (state == DRAIN) & (discard != '0)) | (redirect & rsp_ok);

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt   <= '0;
      perf_flush_cnt   <= '0;
      perf_discard_cnt <= '0;
    end else begin
      perf_fetch_cnt   <= sat_inc(perf_fetch_cnt, gnt_acc);
      perf_flush_cnt   <= sat_inc(perf_flush_cnt, redirect);
      perf_discard_cnt <= sat_inc(perf_discard_cnt, drop);
    end
  end
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding is a bus protocol error; it is ignored.
  a_rvalid_owed : assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (state == FETCH) && (inflight == '0)));

  // The credit limit makes a push into a full queue impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));
`endif

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Directed testbench for if_prefetch_buffer with a pipelined in-order
// instruction memory model of configurable latency. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_if_prefetch_buffer;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc;
  int          lat;
  bit          gnt_en;
  int          n_grants;
  logic [31:0] q_addr[$];
  int          q_due[$];

  if_prefetch_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Memory contents: a fixed function of the word address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Advance to the next cycle and drive the memory side for it.
  task automatic tick();
    @(negedge clk);
    cyc++;
    redirect = 1'b0;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    imem_gnt = gnt_en;
    if (imem_req && imem_gnt) begin
      q_addr.push_back(imem_addr);
      q_due.push_back(cyc + lat);
      n_grants++;
    end
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    out_ready   = 1'b0;
    q_addr.delete();
    q_due.delete();
    n_grants = 0;
    gnt_en   = 1'b1;
    lat      = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_cmp++; if ({out_pc, out_instr} !== 64'h0) begin n_err++; $display("FAIL reset_head: got pc=%h instr=%h want 0/0", out_pc, out_instr); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    apply_reset();
    out_ready = 1'b1;
    tick();  // cycle 1: first request out of reset
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL stream_first_req: got req=%0b addr=%h want 1/00000000", imem_req, imem_addr); end
    tick();  // cycle 2: response on the bus, not yet buffered
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_latency: got valid=%0b want 0 at cycle 2", out_valid); end
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_pc = 32'(i * 4);
      n_cmp++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, exp_pc, instr_of(exp_pc)}) begin
        n_err++;
        $display("FAIL stream_head cyc%0d: got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", cyc, out_valid, out_pc, out_instr, exp_pc, instr_of(exp_pc));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    apply_reset();
    out_ready = 1'b0;
    repeat (10) tick();
    n_cmp++; if (n_grants !== 4) begin n_err++; $display("FAIL bp_grants: got %0d grants want 4", n_grants); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req_low: got %0b want 0", imem_req); end
    n_cmp++; if ({out_valid, out_pc} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL bp_head: got v=%0b pc=%h want 1/00000000", out_valid, out_pc); end
    out_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_pc = 32'(k * 4);
      n_cmp++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, exp_pc, instr_of(exp_pc)}) begin
        n_err++;
        $display("FAIL bp_drain cyc%0d: got v=%0b pc=%h instr=%h want v=1 pc=%h", cyc, out_valid, out_pc, out_instr, exp_pc);
      end
    end
  endtask

  // Two fetches outstanding on a 3-cycle memory, then a redirect to 0x100.
  task automatic redirect_two_inflight();
    apply_reset();
    lat       = 3;
    out_ready = 1'b1;
    tick();
    tick();
    gnt_en = 1'b0;
    tick();  // cycle 3: two fetches outstanding, no new grant
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    gnt_en      = 1'b1;
    tick();  // cycle 4: draining
  endtask

  task automatic test_redirect_drain();
    redirect_two_inflight();
    n_cmp++; if ({imem_req, imem_addr, out_valid} !== {1'b0, 32'h100, 1'b0}) begin n_err++; $display("FAIL drain_enter: got req=%0b addr=%h v=%0b want 0/00000100/0", imem_req, imem_addr, out_valid); end
    tick();  // cycle 5: second stale response dropped
    n_cmp++; if ({imem_req, out_valid} !== 2'b00) begin n_err++; $display("FAIL drain_hold: got req=%0b v=%0b want 0/0", imem_req, out_valid); end
    tick();  // cycle 6: back in FETCH at the target
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL drain_exit: got req=%0b addr=%h want 1/00000100", imem_req, imem_addr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_no_stale cyc%0d: got v=%0b pc=%h want v=0", cyc, out_valid, out_pc); end
    end
    tick();  // cycle 10
    n_cmp++; if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h100, instr_of(32'h100)}) begin n_err++; $display("FAIL drain_first: got v=%0b pc=%h instr=%h want 1/00000100", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_redirect_gnt_rvalid();
    apply_reset();
    out_ready = 1'b1;
    repeat (3) tick();  // cycle 3: head pc 0, grant and response both active
    n_cmp++; if ({out_valid, out_pc, imem_req, imem_rvalid} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin n_err++; $display("FAIL coinc_setup: got v=%0b pc=%h req=%0b want 1/00000000/1", out_valid, out_pc, imem_req); end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();  // cycle 4: one stale response in flight
    n_cmp++; if ({out_valid, imem_req} !== 2'b00) begin n_err++; $display("FAIL coinc_flush: got v=%0b req=%0b want 0/0", out_valid, imem_req); end
    tick();  // cycle 5
    n_cmp++; if ({imem_req, imem_addr, out_valid} !== {1'b1, 32'h100, 1'b0}) begin n_err++; $display("FAIL coinc_addr0: got req=%0b addr=%h v=%0b want 1/00000100/0", imem_req, imem_addr, out_valid); end
    tick();  // cycle 6
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h104}) begin n_err++; $display("FAIL coinc_addr1: got req=%0b addr=%h want 1/00000104", imem_req, imem_addr); end
    tick();  // cycle 7
    n_cmp++; if ({out_valid, out_pc} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL coinc_head0: got v=%0b pc=%h want 1/00000100", out_valid, out_pc); end
    tick();  // cycle 8
    n_cmp++; if ({out_valid, out_pc} !== {1'b1, 32'h104}) begin n_err++; $display("FAIL coinc_head1: got v=%0b pc=%h want 1/00000104", out_valid, out_pc); end
  endtask

  task automatic test_wrap_stall();
    apply_reset();
    out_ready = 1'b1;
    gnt_en    = 1'b0;
    tick();  // cycle 1: request at reset PC, not granted
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;  // low bits must be ignored
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin n_err++; $display("FAIL wrap_stall cyc%0d: got req=%0b addr=%h want 1/fffffffc", cyc, imem_req, imem_addr); end
    end
    gnt_en = 1'b1;
    tick();  // cycle 7: granted
    tick();  // cycle 8
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL wrap_addr: got req=%0b addr=%h want 1/00000000", imem_req, imem_addr); end
    tick();  // cycle 9
    n_cmp++; if ({out_valid, out_pc, out_instr} !== {1'b1, 32'hFFFF_FFFC, instr_of(32'hFFFF_FFFC)}) begin n_err++; $display("FAIL wrap_head0: got v=%0b pc=%h instr=%h want 1/fffffffc", out_valid, out_pc, out_instr); end
    tick();  // cycle 10
    n_cmp++; if ({out_valid, out_pc} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL wrap_head1: got v=%0b pc=%h want 1/00000000", out_valid, out_pc); end
  endtask

  task automatic test_reset_mid_drain();
    redirect_two_inflight();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL rstdrain_bus: got req=%0b addr=%h want 0/00000000", imem_req, imem_addr); end
    n_cmp++; if ({out_valid, out_pc, out_instr} !== {1'b0, 64'h0}) begin n_err++; $display("FAIL rstdrain_head: got v=%0b pc=%h instr=%h want 0/0/0", out_valid, out_pc, out_instr); end
    apply_reset();
    out_ready = 1'b1;
    tick();
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL rstdrain_resume: got req=%0b addr=%h want 1/00000000", imem_req, imem_addr); end
    tick();
    tick();
    n_cmp++; if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, instr_of(32'h0)}) begin n_err++; $display("FAIL rstdrain_head0: got v=%0b pc=%h instr=%h want 1/00000000", out_valid, out_pc, out_instr); end
  endtask

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    out_ready   = 1'b0;
    gnt_en      = 1'b1;
    lat         = 1;
    cyc         = 0;
    n_grants    = 0;
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_drain();
    test_redirect_gnt_rvalid();
    test_wrap_stall();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
